// File: rtl/ram_xfer_sequencer.sv
// ram_xfer_sequencer: queues transfer descriptors in a small circular FIFO and
// issues them one at a time to a RAM<->ECC transfer engine, waiting for the
// engine's completion interrupt (or a timeout) and an idle gap between jobs.
module ram_xfer_sequencer #(
   parameter int DEPTH   = 4,   // descriptor queue entries, power of 2, 2..16
   parameter int TIMEOUT = 63,  // WAIT cycles before abort, 1..255
   parameter int GAP     = 2    // idle cycles between transfers, 1..7
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       desc_valid,
   output logic       desc_ready,
   input  logic       desc_dir,
   input  logic [5:0] desc_rd_addr,
   input  logic [5:0] desc_wr_addr,
   input  logic [1:0] desc_chunks,
   output logic       xfer_command,
   output logic       xfer_rw,
   output logic [5:0] xfer_rd_addr,
   output logic [5:0] xfer_wr_addr,
   output logic [1:0] xfer_chunks,
   input  logic       xfer_interupt,
   output logic       busy,
   output logic       done_pulse,
   output logic       timeout_err,
   output logic       drop_err,
   output logic       spur_err,
   input  logic       err_clear,
   output logic [4:0] pending
);

   localparam int         PW      = $clog2(DEPTH);
   localparam logic [4:0] DEPTH_L = 5'(DEPTH);
   localparam logic [7:0] TMO_L   = 8'(TIMEOUT);
   localparam logic [2:0] GAP_M1  = 3'(GAP - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      GAP_ST = 2'd2
   } state_t;

   typedef struct packed {
      logic       dir;
      logic [5:0] rd_addr;
      logic [5:0] wr_addr;
      logic [1:0] chunks;
   } desc_t;

   state_t          r_state;
   state_t          w_next_state;
   desc_t           r_mem [DEPTH];
   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_rd_ptr;
   logic [4:0]      r_count;
   logic [7:0]      r_tmo_cnt;
   logic [2:0]      r_gap_cnt;
   logic            r_cmd;
   desc_t           r_xfer;
   logic            r_done;
   logic            r_tmo_err;
   logic            r_drop_err;
   logic            r_spur_err;

   logic            w_accept;
   logic            w_push;
   logic            w_drop;
   logic            w_issue;
   logic            w_done;
   logic            w_timeout;
   logic            w_spur;
   desc_t           w_wdesc;

   // Handshake: no bypass when full, even if the head is popped this cycle.
   assign desc_ready = (r_count < DEPTH_L);
   assign w_accept   = desc_valid & desc_ready;
   assign w_push     = w_accept & (desc_chunks != 2'd0);
   assign w_drop     = w_accept & (desc_chunks == 2'd0);
   assign w_spur     = xfer_interupt & (r_state != WAIT);
   assign w_wdesc    = '{dir: desc_dir, rd_addr: desc_rd_addr,
                         wr_addr: desc_wr_addr, chunks: desc_chunks};

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: clocked state uses non-blocking (<=) so every flop samples
      // pre-edge values regardless of block ordering.
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next_state;
   end

   // Next-state decode plus the one-cycle events that drive registered outputs.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it
      // unassigned, which would infer a latch.
      w_next_state = r_state;
      w_issue      = 1'b0;
      w_done       = 1'b0;
      w_timeout    = 1'b0;
      case (r_state)
         IDLE: begin
            if (r_count != 5'd0) begin
               w_issue      = 1'b1;
               w_next_state = WAIT;
            end
         end
         WAIT: begin
            // The interrupt wins over a timeout landing on the same cycle.
            if (xfer_interupt) begin
               w_done       = 1'b1;
               w_next_state = GAP_ST;
            end else if (r_tmo_cnt == TMO_L) begin
               w_timeout    = 1'b1;
               w_next_state = GAP_ST;
            end
         end
         GAP_ST: begin
            if (r_gap_cnt == GAP_M1) w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   // Descriptor storage; written on push only.
   always_ff @(posedge clk) begin
      // NOTE: the storage array is deliberately not reset; the pointers and
      // count define which entries are valid, so stale contents are harmless.
      if (w_push) r_mem[r_wr_ptr] <= w_wdesc;
   end

   // Queue pointers and occupancy; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push)  r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_issue) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_issue})
            2'b10:   r_count <= r_count + 5'd1;
            2'b01:   r_count <= r_count - 5'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // WAIT timeout counter and GAP_ST dwell counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_tmo_cnt <= '0;
         r_gap_cnt <= '0;
      end else begin
         if (w_issue)              r_tmo_cnt <= '0;
         else if (r_state == WAIT) r_tmo_cnt <= r_tmo_cnt + 8'd1;
         if (r_state == GAP_ST)    r_gap_cnt <= r_gap_cnt + 3'd1;
         else                      r_gap_cnt <= '0;
      end
   end

   // Engine command pulse, held transfer fields and completion pulse.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cmd  <= 1'b0;
         r_xfer <= '0;
         r_done <= 1'b0;
      end else begin
         r_cmd  <= w_issue;
         r_done <= w_done;
         if (w_issue) r_xfer <= r_mem[r_rd_ptr];
      end
   end

   // Sticky error flags; a set event in the same cycle beats err_clear.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_tmo_err  <= 1'b0;
         r_drop_err <= 1'b0;
         r_spur_err <= 1'b0;
      end else begin
         if (w_timeout)      r_tmo_err  <= 1'b1;
         else if (err_clear) r_tmo_err  <= 1'b0;
         if (w_drop)         r_drop_err <= 1'b1;
         else if (err_clear) r_drop_err <= 1'b0;
         if (w_spur)         r_spur_err <= 1'b1;
         else if (err_clear) r_spur_err <= 1'b0;
      end
   end

   assign xfer_command = r_cmd;
   assign xfer_rw      = r_xfer.dir;
   assign xfer_rd_addr = r_xfer.rd_addr;
   assign xfer_wr_addr = r_xfer.wr_addr;
   assign xfer_chunks  = r_xfer.chunks;
   assign done_pulse   = r_done;
   assign timeout_err  = r_tmo_err;
   assign drop_err     = r_drop_err;
   assign spur_err     = r_spur_err;
   assign pending      = r_count;
   assign busy         = (r_state != IDLE) || (r_count != 5'd0);

endmodule

// File: tb/tb_ram_xfer_sequencer.sv
// Testbench for ram_xfer_sequencer: a cycle-by-cycle vector table for the
// single-transfer / drop / spurious cases, then hand-written sequences for
// queue-full stall with wrap, timeout, interrupt/timeout coincidence and
// reset in the middle of a transfer.
module tb_ram_xfer_sequencer;

   logic       clk;
   logic       rst_n;
   logic       desc_valid;
   logic       desc_ready;
   logic       desc_dir;
   logic [5:0] desc_rd_addr;
   logic [5:0] desc_wr_addr;
   logic [1:0] desc_chunks;
   logic       xfer_command;
   logic       xfer_rw;
   logic [5:0] xfer_rd_addr;
   logic [5:0] xfer_wr_addr;
   logic [1:0] xfer_chunks;
   logic       xfer_interupt;
   logic       busy;
   logic       done_pulse;
   logic       timeout_err;
   logic       drop_err;
   logic       spur_err;
   logic       err_clear;
   logic [4:0] pending;

   ram_xfer_sequencer #(.DEPTH(4), .TIMEOUT(63), .GAP(2)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .desc_valid   (desc_valid),
      .desc_ready   (desc_ready),
      .desc_dir     (desc_dir),
      .desc_rd_addr (desc_rd_addr),
      .desc_wr_addr (desc_wr_addr),
      .desc_chunks  (desc_chunks),
      .xfer_command (xfer_command),
      .xfer_rw      (xfer_rw),
      .xfer_rd_addr (xfer_rd_addr),
      .xfer_wr_addr (xfer_wr_addr),
      .xfer_chunks  (xfer_chunks),
      .xfer_interupt(xfer_interupt),
      .busy         (busy),
      .done_pulse   (done_pulse),
      .timeout_err  (timeout_err),
      .drop_err     (drop_err),
      .spur_err     (spur_err),
      .err_clear    (err_clear),
      .pending      (pending)
   );

   typedef struct packed {
      logic       rst_n;
      logic       valid;
      logic       dir;
      logic [5:0] rd;
      logic [5:0] wr;
      logic [1:0] ch;
      logic       intr;
      logic       clr;
   } in_t;

   typedef struct packed {
      logic       ready;
      logic       cmd;
      logic       rw;
      logic [5:0] rd;
      logic [5:0] wr;
      logic [1:0] ch;
      logic       busy;
      logic       done;
      logic       tmo;
      logic       drop;
      logic       spur;
      logic [4:0] pend;
   } out_t;

   typedef struct {
      in_t  in;
      out_t exp;
   } vec_t;

   localparam int NVEC = 17;

   vec_t        vec [NVEC];
   int          n_vec = 0;
   int          n_err = 0;
   logic [14:0] desc_b [5];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case a sequence wedges despite its own bounds.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic in_t mk_in(input logic r, v, d, input logic [5:0] rd, wr,
                                 input logic [1:0] ch, input logic it, cl);
      return {r, v, d, rd, wr, ch, it, cl};
   endfunction

   function automatic out_t mk_out(input logic rdy, cmd, rw, input logic [5:0] rd, wr,
                                   input logic [1:0] ch, input logic bsy, dn, tm, dr, sp,
                                   input logic [4:0] pd);
      return {rdy, cmd, rw, rd, wr, ch, bsy, dn, tm, dr, sp, pd};
   endfunction

   function automatic out_t sample();
      return {desc_ready, xfer_command, xfer_rw, xfer_rd_addr, xfer_wr_addr, xfer_chunks,
              busy, done_pulse, timeout_err, drop_err, spur_err, pending};
   endfunction

   function automatic logic [14:0] fields();
      return {xfer_rw, xfer_rd_addr, xfer_wr_addr, xfer_chunks};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input in_t i);
      rst_n         = i.rst_n;
      desc_valid    = i.valid;
      desc_dir      = i.dir;
      desc_rd_addr  = i.rd;
      desc_wr_addr  = i.wr;
      desc_chunks   = i.ch;
      xfer_interupt = i.intr;
      err_clear     = i.clr;
   endtask

   task automatic set_desc(input logic [14:0] d);
      desc_valid = 1'b1;
      {desc_dir, desc_rd_addr, desc_wr_addr, desc_chunks} = d;
   endtask

   task automatic pulse_intr();
      xfer_interupt = 1'b1;
      tick();
      xfer_interupt = 1'b0;
   endtask

   task automatic wait_cmd(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 200; k++) begin
         tick();
         if (xfer_command) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
         if (!busy) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   initial begin
      in_t         idle_in;
      out_t        rst_out;
      bit          ok;
      bit          bad;
      logic [14:0] d_a, d_t1, d_t2, d_n;

      drive(mk_in(1'b0, 1'b0, 1'b0, 6'h00, 6'h00, 2'd0, 1'b0, 1'b0));

      idle_in = mk_in(1'b1, 1'b0, 1'b0, 6'h00, 6'h00, 2'd0, 1'b0, 1'b0);
      rst_out = mk_out(1'b1, 1'b0, 1'b0, 6'h00, 6'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);

      // Table: inputs held for one cycle, expected outputs after that edge.
      vec[0] = '{mk_in(1'b0, 1'b0, 1'b0, 6'h00, 6'h00, 2'd0, 1'b0, 1'b0), rst_out};
      vec[1] = '{idle_in, rst_out};
      vec[2] = '{mk_in(1'b1, 1'b1, 1'b1, 6'h05, 6'h10, 2'd3, 1'b0, 1'b0),
                 mk_out(1'b1, 1'b0, 1'b0, 6'h00, 6'h00, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1)};
      vec[3] = '{idle_in,
                 mk_out(1'b1, 1'b1, 1'b1, 6'h05, 6'h10, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0)};
      for (int i = 4; i <= 8; i++)
         vec[i] = '{idle_in,
                    mk_out(1'b1, 1'b0, 1'b1, 6'h05, 6'h10, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0)};
      vec[9]  = '{mk_in(1'b1, 1'b0, 1'b0, 6'h00, 6'h00, 2'd0, 1'b1, 1'b0),
                  mk_out(1'b1, 1'b0, 1'b1, 6'h05, 6'h10, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0)};
      vec[10] = '{idle_in,
                  mk_out(1'b1, 1'b0, 1'b1, 6'h05, 6'h10, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0)};
      vec[11] = '{idle_in,
                  mk_out(1'b1, 1'b0, 1'b1, 6'h05, 6'h10, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0)};
      vec[12] = '{mk_in(1'b1, 1'b0, 1'b0, 6'h00, 6'h00, 2'd0, 1'b1, 1'b0),
                  mk_out(1'b1, 1'b0, 1'b1, 6'h05, 6'h10, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0)};
      vec[13] = '{mk_in(1'b1, 1'b1, 1'b0, 6'h01, 6'h02, 2'd0, 1'b0, 1'b0),
                  mk_out(1'b1, 1'b0, 1'b1, 6'h05, 6'h10, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0)};
      vec[14] = '{mk_in(1'b1, 1'b0, 1'b0, 6'h00, 6'h00, 2'd0, 1'b0, 1'b1),
                  mk_out(1'b1, 1'b0, 1'b1, 6'h05, 6'h10, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0)};
      vec[15] = '{mk_in(1'b1, 1'b0, 1'b0, 6'h00, 6'h00, 2'd0, 1'b1, 1'b1),
                  mk_out(1'b1, 1'b0, 1'b1, 6'h05, 6'h10, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0)};
      vec[16] = '{mk_in(1'b1, 1'b0, 1'b0, 6'h00, 6'h00, 2'd0, 1'b0, 1'b1),
                  mk_out(1'b1, 1'b0, 1'b1, 6'h05, 6'h10, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0)};

      for (int i = 0; i < NVEC; i++) begin
         drive(vec[i].in);
         tick();
         check($sformatf("vec%0d", i), 32'(sample()), 32'(vec[i].exp));
      end
      drive(idle_in);

      // Queue full stall, FIFO order and pointer wrap.
      d_a = {1'b0, 6'h3F, 6'h00, 2'd1};
      for (int i = 0; i < 5; i++)
         desc_b[i] = {i[0], 6'(32 + i), 6'(8 + i), 2'((i % 3) + 1)};
      set_desc(d_a);
      tick();
      desc_valid = 1'b0;
      wait_cmd(ok);
      check("b2b_a_cmd_seen", 32'(ok), 32'd1);
      check("b2b_a_fields", 32'(fields()), 32'(d_a));
      for (int i = 0; i < 4; i++) begin
         set_desc(desc_b[i]);
         tick();
      end
      set_desc(desc_b[4]);
      check("b2b_full_ready", 32'(desc_ready), 32'd0);
      check("b2b_full_pending", 32'(pending), 32'd4);
      repeat (3) tick();
      check("b2b_stall_ready", 32'(desc_ready), 32'd0);
      check("b2b_stall_pending", 32'(pending), 32'd4);
      pulse_intr();
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (desc_ready) begin
            ok = 1'b1;
            break;
         end
      end
      check("b2b_ready_after_pop", 32'(ok), 32'd1);
      check("b2b_b0_cmd", 32'(xfer_command), 32'd1);
      check("b2b_b0_fields", 32'(fields()), 32'(desc_b[0]));
      tick();
      desc_valid = 1'b0;
      check("b2b_refill_pending", 32'(pending), 32'd4);
      for (int i = 1; i < 5; i++) begin
         pulse_intr();
         wait_cmd(ok);
         check($sformatf("b2b_b%0d_cmd_seen", i), 32'(ok), 32'd1);
         check($sformatf("b2b_b%0d_fields", i), 32'(fields()), 32'(desc_b[i]));
      end
      pulse_intr();
      wait_idle(ok);
      check("b2b_idle", 32'(ok), 32'd1);
      check("b2b_pending_zero", 32'(pending), 32'd0);

      // Timeout, then next descriptor after GAP, then err_clear.
      d_t1 = {1'b1, 6'h11, 6'h22, 2'd2};
      d_t2 = {1'b0, 6'h33, 6'h01, 2'd1};
      set_desc(d_t1);
      tick();
      set_desc(d_t2);
      tick();
      desc_valid = 1'b0;
      check("tmo_t1_cmd", 32'(xfer_command), 32'd1);
      check("tmo_t1_fields", 32'(fields()), 32'(d_t1));
      repeat (63) tick();
      check("tmo_not_yet", 32'(timeout_err), 32'd0);
      tick();
      check("tmo_set", 32'(timeout_err), 32'd1);
      check("tmo_no_done", 32'(done_pulse), 32'd0);
      repeat (3) tick();
      check("tmo_t2_cmd", 32'(xfer_command), 32'd1);
      check("tmo_t2_fields", 32'(fields()), 32'(d_t2));
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      check("tmo_cleared", 32'(timeout_err), 32'd0);

      // Interrupt on the very cycle the counter reaches TIMEOUT.
      repeat (62) tick();
      pulse_intr();
      check("coinc_done", 32'(done_pulse), 32'd1);
      check("coinc_no_tmo", 32'(timeout_err), 32'd0);

      // Reset mid-WAIT with two descriptors queued.
      wait_idle(ok);
      check("rst_pre_idle", 32'(ok), 32'd1);
      set_desc({1'b1, 6'h01, 6'h02, 2'd1});
      tick();
      set_desc({1'b0, 6'h03, 6'h04, 2'd2});
      tick();
      set_desc({1'b1, 6'h05, 6'h06, 2'd3});
      tick();
      desc_valid = 1'b0;
      check("rst_pre_pending", 32'(pending), 32'd2);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("rst_outputs", 32'(sample()), 32'(rst_out));
      bad = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (xfer_command || done_pulse || busy) bad = 1'b1;
      end
      check("rst_quiet", 32'(bad), 32'd0);
      d_n = {1'b1, 6'h2A, 6'h15, 2'd2};
      set_desc(d_n);
      tick();
      desc_valid = 1'b0;
      check("rst_new_cycle1", 32'(xfer_command), 32'd0);
      tick();
      check("rst_new_cmd", 32'(xfer_command), 32'd1);
      check("rst_new_fields", 32'(fields()), 32'(d_n));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ram_xfer_sequencer.md
RAM_XFER_SEQUENCER -- requirements
Module: ram_xfer_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, descriptor queue entries (power of 2, 2..16).
REQ-002 SHALL have parameter TIMEOUT, default 63, maximum WAIT cycles before abort (1..255).
REQ-003 SHALL have parameter GAP, default 2, idle cycles between transfers (1..7).
REQ-004 SHALL have ports:
- clk  in  1  sole clock; all logic on posedge; one clock domain.
- rst_n  in  1  reset; synchronous, active-low.
- desc_valid  in  1  descriptor offered.
- desc_ready  out  1  queue can accept.
- desc_dir  in  1  1 = ECC->RAM, 0 = RAM->ECC.
- desc_rd_addr  in  6  source address.
- desc_wr_addr  in  6  destination address.
- desc_chunks  in  2  chunk count, 1..3.
- xfer_command  out  1  one-cycle start pulse to transfer engine.
- xfer_rw  out  1  direction to engine.
- xfer_rd_addr  out  6  read address to engine.
- xfer_wr_addr  out  6  write address to engine.
- xfer_chunks  out  2  chunk count to engine.
- xfer_interupt  in  1  engine completion pulse.
- busy  out  1  state is not IDLE, or queue not empty.
- done_pulse  out  1  one-cycle flag per completed transfer.
- timeout_err  out  1  sticky; transfer aborted on timeout.
- drop_err  out  1  sticky; descriptor with chunks = 0 discarded.
- spur_err  out  1  sticky; xfer_interupt seen outside WAIT.
- err_clear  in  1  clears sticky error flags.
- pending  out  5  queued descriptor count, 0..DEPTH.

Function
REQ-005 SHALL accept a descriptor on a cycle with desc_valid & desc_ready; desc_ready = (pending < DEPTH), with no bypass when full even if a pop occurs in the same cycle.
REQ-006 SHALL discard an accepted descriptor with desc_chunks = 0 without queuing it, setting drop_err.
REQ-007 SHALL store descriptors FIFO-ordered in a circular buffer; read/write pointers wrap from DEPTH-1 to 0.
REQ-008 SHALL handle push and pop in the same cycle with pending unchanged.
REQ-009 SHALL implement FSM states IDLE, WAIT, GAP_ST.
REQ-010 IDLE, pending > 0: SHALL pop the head at the clock edge, register xfer_rw/rd_addr/wr_addr/chunks, pulse xfer_command high for exactly the next cycle, clear the timeout counter, and go to WAIT.
REQ-011 With the queue empty and in IDLE: SHALL assert xfer_command in the second cycle after the accepting edge.
REQ-012 SHALL hold xfer_rw/rd_addr/wr_addr/chunks stable from the issue edge until the next issue.
REQ-013 WAIT: SHALL increment the 8-bit timeout counter each cycle.
REQ-014 WAIT, on xfer_interupt = 1: SHALL pulse done_pulse for one cycle and go to GAP_ST.
REQ-015 WAIT, counter = TIMEOUT with no xfer_interupt: SHALL set timeout_err, drop the transfer with no retry, and go to GAP_ST.
REQ-016 When xfer_interupt and the timeout coincide, the interrupt SHALL win: done_pulse, no timeout_err.
REQ-017 GAP_ST: SHALL stay exactly GAP cycles, then go to IDLE; xfer_command = 0 throughout.
REQ-018 SHALL set spur_err when xfer_interupt = 1 in IDLE or GAP_ST; this SHALL NOT change state.
REQ-019 err_clear SHALL zero all sticky flags; a set event in the same cycle SHALL win.
REQ-020 busy SHALL be combinational from state and pending.

Reset
REQ-021 When rst_n = 0 at posedge: SHALL go to IDLE, empty the queue (pending = 0), clear the counter, and zero xfer_command, xfer_rw, xfer_rd_addr, xfer_wr_addr, xfer_chunks, done_pulse and all sticky flags; desc_ready = 1 after reset.
REQ-022 Reset during WAIT or GAP_ST SHALL abandon the transfer; no done_pulse; timeout_err not set.

Verification
REQ-023 Single transfer: push {dir=1, rd=0x05, wr=0x10, chunks=3} when idle -> xfer_command high 2nd cycle after accept with those values; interrupt 6 cycles later -> done_pulse next cycle; IDLE after GAP=2.
REQ-024 Back-to-back: push 5 descriptors with DEPTH=4 -> 5th stalls (desc_ready=0) until first pop; issue order matches push order; pointers wrap.
REQ-025 Timeout: no interrupt -> timeout_err set after 63 WAIT cycles; next descriptor issued after GAP; err_clear clears it.
REQ-026 Coincidence: interrupt on the cycle counter = TIMEOUT -> done_pulse, timeout_err stays 0.
REQ-027 Illegal/spurious: chunks=0 push -> drop_err, pending unchanged; interrupt pulse in IDLE -> spur_err, no state change.
REQ-028 Reset mid-WAIT with 2 queued -> pending=0, all outputs 0, no xfer_command until new push.
